// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module  : core_pkg
// Purpose : Shared encodings for the RV32I core front end. These are the
//           branch-decision codes from the EX branch unit, the canonical NOP,
//           and the fetch sequencer state type.
// Revision: 1.0 - initial release
// ============================================================================
package core_pkg;

  // Branch decision driven by the EX-stage branch unit.
  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_COND = 2'b01,
    BR_JALR = 2'b10,
    BR_JAL  = 2'b11
  } br_sel_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_TRAP  = 2'd3
  } pc_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/pc_target.sv
`default_nettype none
// ============================================================================
// Module  : pc_target
// Purpose : Redirect target computation. Conditional branches and JAL use
//           ex_pc + imm, and JALR uses rs1+imm with bit 0 cleared. The
//           module also flags targets that are not 4-byte aligned.
// Revision: 1.0 - initial release
// ============================================================================
module pc_target
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      branch_sel_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] alu_result_i,
  output logic [XLEN-1:0] target_o,
  output logic            misaligned_o
);

  // JALR takes the ALU sum with bit 0 forced low; everything else is PC-relative.
  always_comb begin
    target_o = ex_pc_i + imm_i;
    if (branch_sel_i == BR_JALR) begin
      target_o = alu_result_i & ~XLEN'(1);
    end
  end

  // Bit 0 is either cleared (JALR) or ignored, so only bit 1 matters here.
  assign misaligned_o = target_o[1];

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : pc_sequencer
// Purpose : Program counter and fetch sequencer. It issues single-outstanding
//           instruction fetches and buffers one instruction for decode. It
//           also applies branch redirects with a flush pulse and traps on
//           misaligned targets.
// Revision: 1.0 - initial release
// ============================================================================
module pc_sequencer
  import core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ex_valid_i,
  input  logic [1:0]      branch_sel_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            stall_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            if_valid_o,
  output logic [31:0]     if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic            flush_o,
  output logic            misalign_o
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  pc_seq_state_t   state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            req_q, req_d;
  logic            buf_valid_q, buf_valid_d;
  logic [31:0]     buf_instr_q, buf_instr_d;
  logic [XLEN-1:0] buf_pc_q, buf_pc_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] target_w;
  logic            target_misaligned_w;
  logic            redirect_w;
  logic            ack_w;
  logic            consume_w;

  pc_target #(
    .XLEN(XLEN)
  ) u_pc_target (
    .branch_sel_i (branch_sel_i),
    .ex_pc_i      (ex_pc_i),
    .imm_i        (imm_i),
    .alu_result_i (alu_result_i),
    .target_o     (target_w),
    .misaligned_o (target_misaligned_w)
  );

  // A trapped sequencer ignores the branch unit entirely.
  assign redirect_w = ex_valid_i && (branch_sel_i != BR_NONE) && (state_q != ST_TRAP);
  // Acks are only meaningful while a request is actually on the bus.
  assign ack_w      = imem_ack_i && req_q;
  assign consume_w  = buf_valid_q && !stall_i;

  // Next-state logic. The FSM, pc, fetch address, and output buffer are computed here.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    buf_valid_d = buf_valid_q && !consume_w;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    misalign_d  = misalign_q;

    if (redirect_w) begin
      buf_valid_d = 1'b0;
      pc_d        = target_w;
      if (target_misaligned_w) begin
        state_d    = ST_TRAP;
        misalign_d = 1'b1;
        addr_d     = target_w;
      end else if (req_q && !ack_w) begin
        // The old request must finish on its original address before the
        // target is presented.
        state_d = ST_DRAIN;
      end else begin
        state_d = ST_FETCH;
        addr_d  = target_w;
      end
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (ack_w) begin
            if (buf_valid_q && stall_i) begin
              // No room for this word. Drop it without advancing pc, so it is
              // refetched once decode drains the buffer.
              state_d = ST_HOLD;
            end else begin
              buf_valid_d = 1'b1;
              buf_instr_d = imem_rdata_i;
              buf_pc_d    = addr_q;
              pc_d        = pc_q + PC_STEP;
              addr_d      = pc_q + PC_STEP;
            end
          end
        end
        ST_HOLD: begin
          if (!stall_i) begin
            state_d = ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (ack_w) begin
            state_d = ST_FETCH;
            addr_d  = pc_q;
          end
        end
        default: begin
        end
      endcase
    end

    req_d = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
  end

  // State and registered outputs. imem_req_o stays low until the first edge after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      req_q       <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_instr_q <= NOP_INSTR;
      buf_pc_q    <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      misalign_q  <= misalign_d;
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;
  assign if_valid_o  = buf_valid_q;
  assign if_instr_o  = buf_instr_q;
  assign if_pc_o     = buf_pc_q;
  assign flush_o     = redirect_w;
  assign misalign_o  = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_sequencer
// Purpose : Self-checking bench for pc_sequencer. It covers the directed
//           scenarios and a randomized phase, all checked against a
//           transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ex_valid_i = 1'b0;
  logic [1:0]  branch_sel_i = 2'b00;
  logic [31:0] ex_pc_i = '0;
  logic [31:0] imm_i = '0;
  logic [31:0] alu_result_i = '0;
  logic        stall_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic        flush_o;
  logic        misalign_o;

  pc_sequencer #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ex_valid_i   (ex_valid_i),
    .branch_sel_i (branch_sel_i),
    .ex_pc_i      (ex_pc_i),
    .imm_i        (imm_i),
    .alu_result_i (alu_result_i),
    .stall_i      (stall_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .if_valid_o   (if_valid_o),
    .if_instr_o   (if_instr_o),
    .if_pc_o      (if_pc_o),
    .flush_o      (flush_o),
    .misalign_o   (misalign_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model. It tracks the bus request, the fetch cursor, a
  // one-entry decode queue, and the mode flags.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        m_buf[$];
  bit          m_req, m_hold, m_drain, m_trap, m_mis;
  logic [31:0] m_pc, m_addr;
  logic [31:0] held_instr;

  task automatic check_outputs();
    check_eq("req", imem_req_o, m_req);
    if (m_req) check_eq("addr", imem_addr_o, m_addr);
    check_eq("if_valid", if_valid_o, m_buf.size() > 0);
    if (m_buf.size() > 0) begin
      check_eq("if_instr", if_instr_o, m_buf[0].instr);
      check_eq("if_pc", if_pc_o, m_buf[0].pc);
    end
    check_eq("misalign", misalign_o, m_mis);
  endtask

  // Called at a falling edge. Drive one cycle of inputs and advance the
  // model, then check the registered outputs at the next falling edge.
  task automatic step(input bit exv, input logic [1:0] sel, input logic [31:0] expc,
                      input logic [31:0] imm, input logic [31:0] alu,
                      input bit stall, input bit ack_en);
    logic [31:0] tgt;
    bit          redir;
    bit          ackd;
    ent_t        e;
    ackd         = ack_en && m_req;
    ex_valid_i   = exv;
    branch_sel_i = sel;
    ex_pc_i      = expc;
    imm_i        = imm;
    alu_result_i = alu;
    stall_i      = stall;
    imem_ack_i   = ackd;
    imem_rdata_i = $urandom;
    #1;
    redir = exv && (sel != 2'b00) && !m_trap;
    check_eq("flush", flush_o, redir);
    tgt = (sel == 2'b10) ? {alu[31:1], 1'b0} : expc + imm;
    if (redir) begin
      m_buf.delete();
      m_pc = tgt;
      if (tgt[1]) begin
        m_trap = 1; m_mis = 1; m_req = 0; m_hold = 0; m_drain = 0;
      end else if (m_req && !ackd) begin
        m_drain = 1;
      end else begin
        m_drain = 0; m_hold = 0; m_req = 1; m_addr = tgt;
      end
    end else if (!m_trap) begin
      if (m_buf.size() > 0 && !stall) void'(m_buf.pop_front());
      if (m_hold) begin
        if (!stall) begin
          m_hold = 0; m_req = 1; m_addr = m_pc;
        end
      end else if (m_drain) begin
        if (ackd) begin
          m_drain = 0; m_addr = m_pc;
        end
      end else if (!m_req) begin
        m_req = 1;
      end else if (ackd) begin
        if (m_buf.size() > 0) begin
          m_hold = 1; m_req = 0;
        end else begin
          e.instr = imem_rdata_i;
          e.pc    = m_addr;
          m_buf.push_back(e);
          m_pc   = m_pc + 32'd4;
          m_addr = m_pc;
        end
      end
    end
    @(negedge clk_i);
    check_outputs();
  endtask

  task automatic idle(input bit stall, input bit ack_en);
    step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, stall, ack_en);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    imem_ack_i = 1'b0;
    ex_valid_i = 1'b0;
    stall_i    = 1'b0;
    rst_i      = 1'b1;
    #1;
    check_eq("rst_req", imem_req_o, 32'h0);
    check_eq("rst_addr", imem_addr_o, 32'h0);
    check_eq("rst_valid", if_valid_o, 32'h0);
    check_eq("rst_instr", if_instr_o, NOP);
    check_eq("rst_pc", if_pc_o, 32'h0);
    check_eq("rst_flush", flush_o, 32'h0);
    check_eq("rst_misalign", misalign_o, 32'h0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    m_buf.delete();
    m_req = 0; m_hold = 0; m_drain = 0; m_trap = 0; m_mis = 0;
    m_pc = 32'h0; m_addr = 32'h0;
  endtask

  initial begin
    // Sequential fetch with zero-wait memory.
    do_reset();
    idle(1'b0, 1'b1);
    check_eq("first_req", imem_req_o, 32'h1);
    check_eq("first_valid", if_valid_o, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      idle(1'b0, 1'b1);
      check_eq("seq_addr", imem_addr_o, 32'(4 * i));
      check_eq("seq_if_pc", if_pc_o, 32'(4 * (i - 1)));
    end

    // Backward conditional branch drops the buffered instruction.
    step(1'b1, 2'b01, 32'h40, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b1);
    check_eq("cond_addr", imem_addr_o, 32'h30);
    check_eq("cond_drop", if_valid_o, 32'h0);
    idle(1'b0, 1'b1);
    check_eq("cond_if_pc", if_pc_o, 32'h30);

    // Redirect while the fetch to 0x10 is still unacknowledged.
    do_reset();
    idle(1'b0, 1'b1);
    repeat (4) idle(1'b0, 1'b1);
    check_eq("pre_drain_addr", imem_addr_o, 32'h10);
    step(1'b1, 2'b11, 32'h70, 32'h10, 32'h0, 1'b0, 1'b0);
    check_eq("drain_addr_hold", imem_addr_o, 32'h10);
    check_eq("drain_req", imem_req_o, 32'h1);
    idle(1'b0, 1'b0);
    check_eq("drain_addr_hold2", imem_addr_o, 32'h10);
    idle(1'b0, 1'b1);
    check_eq("drain_discard", if_valid_o, 32'h0);
    check_eq("drain_next", imem_addr_o, 32'h80);
    idle(1'b0, 1'b1);
    check_eq("drain_if_pc", if_pc_o, 32'h80);

    // Decode stall with a full buffer.
    held_instr = if_instr_o;
    for (int i = 0; i < 3; i++) begin
      idle(1'b1, 1'b1);
      check_eq("stall_req", imem_req_o, 32'h0);
      check_eq("stall_instr", if_instr_o, held_instr);
      check_eq("stall_pc", if_pc_o, 32'h80);
    end
    idle(1'b0, 1'b1);
    check_eq("resume_addr", imem_addr_o, 32'h84);
    idle(1'b0, 1'b1);
    check_eq("resume_if_pc", if_pc_o, 32'h84);

    // JAL wrapping past the top of the address space, concurrent with a stall.
    step(1'b1, 2'b11, 32'hFFFF_FFFC, 32'h8, 32'h0, 1'b1, 1'b1);
    check_eq("wrap_addr", imem_addr_o, 32'h4);
    idle(1'b0, 1'b1);
    check_eq("wrap_if_pc", if_pc_o, 32'h4);

    // Misaligned JALR traps until reset.
    step(1'b1, 2'b10, 32'h0, 32'h0, 32'h0000_0103, 1'b0, 1'b1);
    check_eq("trap_misalign", misalign_o, 32'h1);
    check_eq("trap_req", imem_req_o, 32'h0);
    step(1'b1, 2'b01, 32'h100, 32'h20, 32'h0, 1'b0, 1'b1);
    repeat (3) idle(1'b0, 1'b1);
    check_eq("trap_req_late", imem_req_o, 32'h0);

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      logic [31:0] alu;
      alu = $urandom;
      if ($urandom_range(0, 15) != 0) alu[1] = 1'b0;
      step($urandom_range(0, 7) == 0, 2'($urandom), $urandom & ~32'h3,
           $urandom & ~32'h3, alu, $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) < 7);
      if (m_trap && $urandom_range(0, 7) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
